// File: rtl/add_sub_pkg.sv
// add_sub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   OP_ADD / OP_SUB : encodings of the ctrl input.
//   sat_limit()     : most-positive / most-negative two's-complement value
//                     for a given width, returned in a 64-bit container.
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // pos = 1 -> 0x7F..F, pos = 0 -> 0x80..0 (low w bits of the result)
    function automatic logic [63:0] sat_limit(input int unsigned w, input logic pos);
        logic [63:0] r;
        r = 64'd1 << (w - 1);
        if (pos) begin
            r = r - 64'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// add_sub_slice
// SLICE-bit combinational ripple adder/subtractor built from full_adder cells.
//   a, b     : operand slices
//   ctrl     : OP_ADD adds b, OP_SUB adds ~b
//   cin      : carry into bit 0
//   sum      : slice sum
//   cout     : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (used for signed overflow)
module add_sub_slice
    import add_sub_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ctrl,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] bx;

    assign bx = (ctrl == OP_SUB) ? ~b : b;

    // Each bit keeps its own carry signals so the chain is a set of
    // distinct nets rather than one vector feeding itself.
    for (genvar i = 0; i < SLICE; i++) begin : fa_bit
        logic ci;
        logic co;

        if (i == 0) begin : c_src
            assign ci = cin;
        end else begin : c_src
            assign ci = fa_bit[i-1].co;
        end

        full_adder u_fa (
            .a    (a[i]),
            .b    (bx[i]),
            .cin  (ci),
            .sum  (sum[i]),
            .cout (co)
        );
    end

    assign cout     = fa_bit[SLICE-1].co;
    assign c_msb_in = fa_bit[SLICE-1].ci;

endmodule

// File: rtl/full_adder.sv
// full_adder
// One-bit full-adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
// WIDTH-bit adder/subtractor with the carry chain split into STAGES registered
// slices, valid/ready handshakes, signed-overflow flag and optional saturation.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : input handshake
//   a, b, ctrl, sat      : operands, 0=add 1=sub, clamp on signed overflow
//   out_valid, out_ready : output handshake
//   s, cout, ovf         : registered result, carry out of MSB, signed overflow
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam logic [63:0] MAX64 = sat_limit(WIDTH, 1'b1);
    localparam logic [63:0] MIN64 = sat_limit(WIDTH, 1'b0);
    localparam logic [WIDTH-1:0] S_MAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] S_MIN = MIN64[WIDTH-1:0];

    logic             stall;
    logic             v_out_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;

    assign stall    = v_out_q && !out_ready;
    assign in_ready = !stall;

    // Intermediate stages 0..STAGES-2. Stage k keeps only the operand bits
    // still to be added (above its slice) and the sum bits computed so far.
    for (genvar k = 0; k < STAGES - 1; k++) begin : stg
        localparam int unsigned HI = (k + 1) * SLICE;
        localparam int unsigned UP = WIDTH - HI;

        logic [SLICE-1:0] a_sl, b_sl, sum_sl;
        logic [UP-1:0]    a_rest, b_rest;
        logic [HI-1:0]    sum_nx;
        logic             cin, ctrl_in, sat_in, v_in, c_out, c_msb_unused;

        logic             v_q, ctrl_q, sat_q, c_q;
        logic [UP-1:0]    a_q, b_q;
        logic [HI-1:0]    sum_q;

        if (k == 0) begin : src
            assign a_sl    = a[SLICE-1:0];
            assign b_sl    = b[SLICE-1:0];
            assign a_rest  = a[WIDTH-1:SLICE];
            assign b_rest  = b[WIDTH-1:SLICE];
            assign cin     = ctrl;
            assign ctrl_in = ctrl;
            assign sat_in  = sat;
            assign v_in    = in_valid;
            assign sum_nx  = sum_sl;
        end else begin : src
            assign a_sl    = stg[k-1].a_q[SLICE-1:0];
            assign b_sl    = stg[k-1].b_q[SLICE-1:0];
            assign a_rest  = stg[k-1].a_q[UP+SLICE-1:SLICE];
            assign b_rest  = stg[k-1].b_q[UP+SLICE-1:SLICE];
            assign cin     = stg[k-1].c_q;
            assign ctrl_in = stg[k-1].ctrl_q;
            assign sat_in  = stg[k-1].sat_q;
            assign v_in    = stg[k-1].v_q;
            assign sum_nx  = {sum_sl, stg[k-1].sum_q};
        end

        add_sub_slice #(.SLICE(SLICE)) u_slice (
            .a        (a_sl),
            .b        (b_sl),
            .ctrl     (ctrl_in),
            .cin      (cin),
            .sum      (sum_sl),
            .cout     (c_out),
            .c_msb_in (c_msb_unused)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                ctrl_q <= 1'b0;
                sat_q  <= 1'b0;
                c_q    <= 1'b0;
                a_q    <= '0;
                b_q    <= '0;
                sum_q  <= '0;
            end else if (!stall) begin
                v_q    <= v_in;
                ctrl_q <= ctrl_in;
                sat_q  <= sat_in;
                c_q    <= c_out;
                a_q    <= a_rest;
                b_q    <= b_rest;
                sum_q  <= sum_nx;
            end
        end
    end

    // Final stage: top slice, overflow detection, saturation, output registers.
    logic [SLICE-1:0] fa_sl, fb_sl, fsum_sl;
    logic             fcin, fctrl, fsat, fv, fcout, fcmsb, ovf_nx;
    logic [WIDTH-1:0] raw_sum, s_nx;

    if (STAGES == 1) begin : fin_src
        assign fa_sl   = a;
        assign fb_sl   = b;
        assign fcin    = ctrl;
        assign fctrl   = ctrl;
        assign fsat    = sat;
        assign fv      = in_valid;
        assign raw_sum = fsum_sl;
    end else begin : fin_src
        assign fa_sl   = stg[STAGES-2].a_q;
        assign fb_sl   = stg[STAGES-2].b_q;
        assign fcin    = stg[STAGES-2].c_q;
        assign fctrl   = stg[STAGES-2].ctrl_q;
        assign fsat    = stg[STAGES-2].sat_q;
        assign fv      = stg[STAGES-2].v_q;
        assign raw_sum = {fsum_sl, stg[STAGES-2].sum_q};
    end

    add_sub_slice #(.SLICE(SLICE)) u_slice_fin (
        .a        (fa_sl),
        .b        (fb_sl),
        .ctrl     (fctrl),
        .cin      (fcin),
        .sum      (fsum_sl),
        .cout     (fcout),
        .c_msb_in (fcmsb)
    );

    // A wrapped result has the wrong sign: negative MSB means positive overflow.
    always_comb begin
        ovf_nx = fcmsb ^ fcout;
        s_nx   = raw_sum;
        if (fsat && ovf_nx) begin
            s_nx = raw_sum[WIDTH-1] ? S_MAX : S_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_out_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (!stall) begin
            v_out_q <= fv;
            s_q     <= s_nx;
            cout_q  <= fcout;
            ovf_q   <= ovf_nx;
        end
    end

    assign out_valid = v_out_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub
// Directed self-checking bench for pipelined_add_sub (WIDTH=16, STAGES=4).
module tb_pipelined_add_sub;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ctrl;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: accepted at edge N, valid only in the cycle after N+3.
    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ic, input logic isat,
                          input logic [15:0] es, input logic ec, input logic eo);
        a = ia; b = ib; ctrl = ic; sat = isat; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 3; i++) begin
            check({tag, " early_valid"}, 32'(out_valid), 32'd0);
            tick();
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " s"},         32'(s),         32'(es));
        check({tag, " cout"},      32'(cout),      32'(ec));
        check({tag, " ovf"},       32'(ovf),       32'(eo));
        tick();
        check({tag, " valid_after"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] exp_s [8];
    logic        exp_c [8];
    logic [16:0] r17;
    logic [15:0] bx;
    int          sent;
    int          rcv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ctrl = 1'b0; sat = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset s",         32'(s),         32'd0);
        check("reset cout",      32'(cout),      32'd0);
        check("reset ovf",       32'(ovf),       32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);

        run_op("add1",     16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335, 1'b0, 1'b0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_nob",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
        run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sat_add",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        run_op("sat_sub",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
        run_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: 8 beats a=i, b=2i, ctrl=i[0]; stall in cycles 6..8 after first accept.
        for (int j = 0; j < 8; j++) begin
            bx = 16'(2 * j);
            if (j % 2 == 1) bx = ~bx;
            r17 = {1'b0, 16'(j)} + {1'b0, bx} + 17'(j % 2);
            exp_s[j] = r17[15:0];
            exp_c[j] = r17[16];
        end
        sent = 0;
        rcv  = 0;
        sat  = 1'b0;
        for (int t = 0; t < 30; t++) begin
            out_ready = !(t >= 7 && t <= 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                a        = 16'(sent);
                b        = 16'(2 * sent);
                ctrl     = sent[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t >= 7 && t <= 9) begin
                check("bp stall in_ready",  32'(in_ready),  32'd0);
                check("bp stall out_valid", 32'(out_valid), 32'd1);
                check("bp stall s_held",    32'(s),         32'(exp_s[3]));
            end else begin
                check("bp in_ready", 32'(in_ready), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (rcv < 8) begin
                    check("bp s",    32'(s),    32'(exp_s[rcv]));
                    check("bp cout", 32'(cout), 32'(exp_c[rcv]));
                    check("bp ovf",  32'(ovf),  32'd0);
                end else begin
                    check("bp extra beat", 32'(rcv), 32'd7);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp sent count",     32'(sent), 32'd8);
        check("bp received count", 32'(rcv),  32'd8);

        // Reset with three beats in flight.
        for (int j = 0; j < 3; j++) begin
            a = 16'h0100 + 16'(j); b = 16'h0010; ctrl = 1'b0; sat = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst out_valid", 32'(out_valid), 32'd0);
        check("mid_rst s",         32'(s),         32'd0);
        check("mid_rst cout",      32'(cout),      32'd0);
        check("mid_rst ovf",       32'(ovf),       32'd0);
        check("mid_rst in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst no ghost", 32'(out_valid), 32'd0);
        end

        run_op("post_rst", 16'h0A0A, 16'h0505, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised successor to the 16-bit ripple-carry adder/subtractor.
- Splits the WIDTH-bit carry chain into STAGES registered slices, so the critical path is one slice.
- Adds valid/ready handshakes on input and output, signed-overflow detection and optional signed saturation.
- Sits between operand producers and result consumers in the datapath; one operation accepted per cycle when not stalled.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices; each slice handles SLICE = WIDTH/STAGES bits; legal range 1..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ctrl  input  1  0 = A+B, 1 = A-B (computed as A + ~B + 1).
- sat  input  1  1 = clamp signed overflow to the most positive/most negative value.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  result.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow of the unsaturated result.

Behaviour:
- Reset: when rst is 1 at a rising edge, all stage valid bits clear and all data registers clear to 0. Next cycle out_valid=0, s=0, cout=0, ovf=0 and in_ready=1. Reset mid-stream discards every in-flight beat; nothing is replayed.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid and operands are held by the producer until accepted.
- Stall rule: global stall = out_valid && !out_ready. In a stall every stage holds; in_ready = !stall (combinational from out_ready). Bubbles are not compressed.
- Latency: a beat accepted at edge N has out_valid=1 during the cycle after edge N+STAGES-1, i.e. exactly STAGES cycles, absent stalls. Each stall cycle adds one. Throughput is 1 beat/cycle.
- Stage k (0..STAGES-1):
  - Adds slice k of A and of (ctrl ? ~B : B) with carry-in (stage 0: ctrl; else the registered carry of stage k-1).
  - Registers the slice sum, the carry and valid.
  - Carries forward already-computed lower slices and not-yet-used upper operand slices, together with ctrl and sat.
- Final stage:
  - ovf = carry into MSB XOR carry out of MSB.
  - cout = carry out of MSB.
  - If sat && ovf, s = result MSB ? 0x7F..F : 0x80..0 (positive overflow wraps negative → clamp max; negative → clamp min). Otherwise s = raw sum.
  - ovf reports overflow regardless of sat.
- Outputs change only on edges. s/cout/ovf are registered and stable while out_valid && !out_ready.
- Order: results exit strictly in acceptance order; no beat is dropped or duplicated under any out_ready pattern.
- STAGES=1: single registered ripple adder, latency 1.
- Wrap-around: without sat, arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared package (add_sub_pkg):
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - Function computing the signed max/min constants for a given width.
- Sub-module add_sub_slice: SLICE-bit combinational ripple adder (a, b, ctrl, cin → sum, cout, c_msb_in). It is built from the existing full-adder cell and instantiated once per stage.
- Pipeline registers and handshake live in pipelined_add_sub.

Test Plan (WIDTH=16, STAGES=4):
- Add, in_valid one cycle, out_ready=1:
  - a=0x1234, b=0x0101, ctrl=0, sat=0 → out_valid exactly 4 cycles later, s=0x1335, cout=0, ovf=0.
  - a=0xFFFF, b=0x0001, ctrl=0 → s=0x0000, cout=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, ctrl=1 → s=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 → s=0x0002, cout=1.
- Overflow, add: a=0x7FFF, b=0x0001, ctrl=0.
  - sat=0 → s=0x8000, ovf=1, cout=0.
  - sat=1 → s=0x7FFF, ovf=1.
- Overflow, subtract: a=0x8000, b=0x0001, ctrl=1, sat=1 → s=0x8000, ovf=1, cout=1. With sat=0 → s=0x7FFF.
- Backpressure: 8 back-to-back beats (a=i, b=2i, ctrl=i[0]); out_ready=0 for cycles 6-8 after first accept → in_ready=0 during those cycles, s/out_valid held, all 8 results in order with correct values, no duplicates.
- Reset mid-stream: 3 beats in flight, rst=1 for one edge → next cycle out_valid=0, s=0, in_ready=1. None of the 3 beats ever appears; a new beat afterward returns after 4 cycles.
